ac_result_tx: RTL



---
 rtl/ac_result_tx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ac_result_tx.sv
// ac_result_tx: reads 16-bit result words from data RAM and sends each
// one to the host as two UART 8N1 frames, high byte first.
module ac_result_tx #(
    parameter int ADDR_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [15:0]           mem_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_START_BIT,
        S_DATA_BITS,
        S_STOP_BIT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_cnt;
    logic [2:0]            r_bit_idx;
    logic                  r_byte_hi;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_remain;
    logic [15:0]           r_word;
    logic                  r_cap;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_mem_rd_en;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  w_accept;
    logic                  w_bit_end;
    logic                  w_next_word;
    logic                  w_tx;
    logic [7:0]            w_byte;

    // Outputs are registered from the current state, so they trail it by one
    // cycle; read data therefore lands one cycle after the LATCH state.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_next_word = 1'b0;
        w_bit_end   = (r_cnt == CNT_MAX);
        w_byte      = r_byte_hi ? r_word[15:8] : r_word[7:0];
        w_tx        = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_accept = start && !r_done;
                if (w_accept)
                    w_next = (word_count != '0) ? S_READ : S_DONE;
            end
            S_READ:  w_next = S_LATCH;
            S_LATCH: w_next = S_START_BIT;
            S_START_BIT: begin
                w_tx = 1'b0;
                if (w_bit_end)
                    w_next = S_DATA_BITS;
            end
            S_DATA_BITS: begin
                w_tx = w_byte[r_bit_idx];
                if (w_bit_end && r_bit_idx == 3'd7)
                    w_next = S_STOP_BIT;
            end
            S_STOP_BIT: begin
                if (w_bit_end) begin
                    if (r_byte_hi) begin
                        w_next = S_START_BIT;
                    end else if (r_remain != ADDR_WIDTH'(1)) begin
                        w_next_word = 1'b1;
                        w_next      = S_READ;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_byte_hi   <= 1'b1;
            r_addr      <= '0;
            r_remain    <= '0;
            r_word      <= '0;
            r_cap       <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
        end else begin
            r_state <= w_next;

            if (r_state == S_START_BIT || r_state == S_DATA_BITS ||
                r_state == S_STOP_BIT)
                r_cnt <= w_bit_end ? '0 : r_cnt + CW'(1);
            else
                r_cnt <= '0;

            if (r_state != S_DATA_BITS)
                r_bit_idx <= '0;
            else if (w_bit_end)
                r_bit_idx <= r_bit_idx + 3'd1;

            if (r_state == S_READ)
                r_byte_hi <= 1'b1;
            else if (r_state == S_STOP_BIT && w_bit_end)
                r_byte_hi <= 1'b0;

            if (w_accept) begin
                r_addr   <= base_addr;
                r_remain <= word_count;
            end else if (w_next_word) begin
                r_addr   <= r_addr + ADDR_WIDTH'(1);
                r_remain <= r_remain - ADDR_WIDTH'(1);
            end

            r_cap <= (r_state == S_LATCH);
            if (r_cap)
                r_word <= mem_data;

            r_mem_rd_en <= (r_state == S_READ);
            if (r_state == S_READ)
                r_mem_addr <= r_addr;

            r_tx   <= w_tx;
            r_busy <= (r_state != S_IDLE) && (r_state != S_DONE);
            r_done <= (r_state == S_DONE);
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_rd_en = r_mem_rd_en;
    assign tx        = r_tx;
    assign busy      = r_busy;
    assign done      = r_done;
endmodule
